// File: rtl/instruction_memory_loadable.sv
// Loadable instruction memory: valid/ready program loader plus a registered,
// slot-relative fetch port with an out-of-range fault flag.
module instruction_memory_loadable #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 10,
    parameter int DEPTH      = 1024,
    parameter int SLOT_WORDS = 16,
    parameter int N_PROG     = 4,
    localparam int PSEL_W    = (N_PROG > 1) ? $clog2(N_PROG) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load_start,
    input  logic [ADDR_W-1:0] load_base,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic              load_ready,
    output logic              load_overflow,
    output logic              busy,
    input  logic [PSEL_W-1:0] prog_sel,
    input  logic              fetch_en,
    input  logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] instrucao,
    output logic              instr_valid,
    output logic              addr_fault
);

    // wr_ptr must be able to hold DEPTH itself (saturation point)
    localparam int PTR_W = ADDR_W + 1;
    localparam int EA_W  = ADDR_W + PSEL_W + 1;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        S_EMPTY,
        S_LOAD,
        S_RUN
    } state_t;

    logic [DATA_W-1:0] mem [DEPTH];

    state_t            state_q, state_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic              ovf_q, ovf_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic              ivalid_q, ivalid_d;
    logic              fault_q, fault_d;
    logic              we;
    logic              accept;
    logic              in_range_w;
    logic              in_range_r;
    logic [EA_W-1:0]   ea;

    // Full-width effective address so a large slot/offset never aliases
    assign ea = EA_W'(prog_sel) * EA_W'(SLOT_WORDS) + EA_W'(address);

    assign busy          = (state_q == S_LOAD);
    assign load_ready    = (state_q == S_LOAD) && !load_start;
    assign accept        = load_ready && load_valid;
    assign in_range_w    = (wr_ptr_q < PTR_W'(DEPTH));
    assign in_range_r    = (ea < EA_W'(DEPTH));
    assign load_overflow = ovf_q;
    assign instrucao     = instr_q;
    assign instr_valid   = ivalid_q;
    assign addr_fault    = fault_q;

    // Next-state: loader FSM, write pointer, overflow flag and fetch result
    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        ovf_d    = ovf_q;
        we       = 1'b0;
        instr_d  = instr_q;
        ivalid_d = 1'b0;
        fault_d  = 1'b0;

        if (load_start) begin
            state_d  = S_LOAD;
            wr_ptr_d = PTR_W'(load_base);
            ovf_d    = 1'b0;
        end else if (accept) begin
            if (in_range_w) begin
                we       = 1'b1;
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end else begin
                ovf_d = 1'b1;
            end
            if (load_last) begin
                state_d = S_RUN;
            end
        end

        if ((state_q == S_RUN) && fetch_en) begin
            ivalid_d = 1'b1;
            if (in_range_r) begin
                instr_d = mem[ea[IDX_W-1:0]];
            end else begin
                instr_d = '0;
                fault_d = 1'b1;
            end
        end
    end

    // State and output registers; RAM contents are deliberately excluded
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= S_EMPTY;
            wr_ptr_q <= '0;
            ovf_q    <= 1'b0;
            instr_q  <= '0;
            ivalid_q <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            ovf_q    <= ovf_d;
            instr_q  <= instr_d;
            ivalid_q <= ivalid_d;
            fault_q  <= fault_d;
        end
    end

    // Program RAM write port, only active while loading
    always_ff @(posedge clock) begin
        if (we) begin
            mem[wr_ptr_q[IDX_W-1:0]] <= load_data;
        end
    end

endmodule

// File: tb/tb_instruction_memory_loadable.sv
// Randomized scoreboard bench for instruction_memory_loadable against an
// array/queue reference model of the loader and fetch rules.
module tb_instruction_memory_loadable;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 6;
    localparam int DEPTH  = 32;
    localparam int SLOT   = 16;
    localparam int NPROG  = 4;
    localparam int PSW    = 2;

    localparam int M_EMPTY = 0;
    localparam int M_LOAD  = 1;
    localparam int M_RUN   = 2;

    logic              clock;
    logic              reset;
    logic              load_start;
    logic [ADDR_W-1:0] load_base;
    logic              load_valid;
    logic [DATA_W-1:0] load_data;
    logic              load_last;
    logic              load_ready;
    logic              load_overflow;
    logic              busy;
    logic [PSW-1:0]    prog_sel;
    logic              fetch_en;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] instrucao;
    logic              instr_valid;
    logic              addr_fault;

    instruction_memory_loadable #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .DEPTH     (DEPTH),
        .SLOT_WORDS(SLOT),
        .N_PROG    (NPROG)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .load_start   (load_start),
        .load_base    (load_base),
        .load_valid   (load_valid),
        .load_data    (load_data),
        .load_last    (load_last),
        .load_ready   (load_ready),
        .load_overflow(load_overflow),
        .busy         (busy),
        .prog_sel     (prog_sel),
        .fetch_en     (fetch_en),
        .address      (address),
        .instrucao    (instrucao),
        .instr_valid  (instr_valid),
        .addr_fault   (addr_fault)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [DATA_W-1:0] ins;
        logic              flt;
    } exp_t;

    exp_t              sb[$];
    int                checks = 0;
    int                errors = 0;
    int                m_mode;
    int                m_ptr;
    bit                m_ovf;
    bit                m_acc;
    logic [DATA_W-1:0] m_mem[DEPTH];
    logic [DATA_W-1:0] c0, c1;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, req, $time);
        end
    endtask

    // Reference behaviour at one rising edge, from the current inputs
    task automatic model_edge();
        bit rdy;
        int ea;
        rdy = (m_mode == M_LOAD) && !load_start;
        m_acc = 1'b0;
        if (m_mode == M_RUN && fetch_en) begin
            ea = int'(prog_sel) * SLOT + int'(address);
            if (ea < DEPTH) sb.push_back('{m_mem[ea], 1'b0});
            else sb.push_back('{'0, 1'b1});
        end
        if (load_start) begin
            m_mode = M_LOAD;
            m_ptr  = int'(load_base);
            m_ovf  = 1'b0;
        end else if (rdy && load_valid) begin
            m_acc = 1'b1;
            if (m_ptr < DEPTH) begin
                m_mem[m_ptr] = load_data;
                m_ptr++;
            end else begin
                m_ovf = 1'b1;
            end
            if (load_last) m_mode = M_RUN;
        end
    endtask

    task automatic step();
        @(negedge clock);
        if (!reset) begin
            chk("load_ready", 32'(load_ready),
                32'((m_mode == M_LOAD) && !load_start));
            chk("busy", 32'(busy), 32'(m_mode == M_LOAD));
            chk("load_overflow", 32'(load_overflow), 32'(m_ovf));
        end
        @(posedge clock);
        if (!reset) model_edge();
        #1;
    endtask

    task automatic start_load(int base);
        load_start = 1'b1;
        load_base  = ADDR_W'(base);
        step();
        load_start = 1'b0;
    endtask

    task automatic send_word(logic [DATA_W-1:0] d, bit last, int gap);
        int n;
        load_valid = 1'b0;
        repeat (gap) step();
        load_valid = 1'b1;
        load_data  = d;
        load_last  = last;
        m_acc      = 1'b0;
        n          = 0;
        while (!m_acc && n < 50) begin
            step();
            n++;
        end
        if (!m_acc) begin
            checks++;
            errors++;
            $display("FAIL load_accept_timeout actual=none required=accept");
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic fetch(int ps, int a);
        prog_sel = PSW'(ps);
        address  = ADDR_W'(a);
        fetch_en = 1'b1;
        step();
        fetch_en = 1'b0;
        step();
    endtask

    // Monitor: every presented fetch result is matched against the scoreboard
    always @(negedge clock) begin
        if (!reset) begin
            if (instr_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_fetch actual=valid required=idle");
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("instrucao", instrucao, e.ins);
                    chk("addr_fault", 32'(addr_fault), 32'(e.flt));
                end
            end else begin
                chk("fault_idle", 32'(addr_fault), 32'd0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

    initial begin
        reset      = 1'b1;
        load_start = 1'b0;
        load_base  = '0;
        load_valid = 1'b0;
        load_data  = '0;
        load_last  = 1'b0;
        prog_sel   = '0;
        address    = '0;
        fetch_en   = 1'b1;
        m_mode     = M_EMPTY;
        m_ptr      = 0;
        m_ovf      = 1'b0;
        m_acc      = 1'b0;

        // Reset state, and fetch blocked while EMPTY
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        chk("rst_instr", instrucao, 32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(load_ready), 32'd0);
        chk("rst_ovf", 32'(load_overflow), 32'd0);
        repeat (3) step();
        chk("empty_instr", instrucao, 32'd0);
        fetch_en = 1'b0;

        // Slot 0 load with valid gaps, then fetch each word
        start_load(0);
        chk("busy_load", 32'(busy), 32'd1);
        for (int i = 0; i < 4; i++)
            send_word($urandom, i == 3, $urandom_range(0, 2));
        chk("busy_done", 32'(busy), 32'd0);
        for (int i = 0; i < 4; i++) fetch(0, i);

        // Slot 1 load; slot select picks the right base
        start_load(16);
        send_word($urandom, 1'b0, 1);
        send_word($urandom, 1'b1, 0);
        fetch(1, 1);
        fetch(0, 1);

        // Effective address exactly DEPTH faults
        fetch(2, 0);

        // Load running past the top of memory
        start_load(DEPTH - 2);
        for (int i = 0; i < 3; i++) send_word($urandom, i == 2, 0);
        chk("ovf_set", 32'(load_overflow), 32'd1);
        chk("ovf_run", 32'(busy), 32'd0);
        fetch(1, 14);
        fetch(1, 15);

        // Reset mid-load keeps already written words
        start_load(0);
        c0 = $urandom;
        c1 = $urandom;
        send_word(c0, 1'b0, 0);
        send_word(c1, 1'b0, 1);
        reset  = 1'b1;
        m_mode = M_EMPTY;
        m_ptr  = 0;
        m_ovf  = 1'b0;
        #1;
        chk("midrst_ready", 32'(load_ready), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        step();
        reset = 1'b0;
        step();
        start_load(2);
        for (int i = 2; i < DEPTH; i++)
            send_word($urandom, i == DEPTH - 1, 0);
        fetch(0, 0);
        fetch(0, 1);
        chk("kept_c0", m_mem[0], c0);
        chk("kept_c1", m_mem[1], c1);

        // Randomized fetch traffic with occasional (re)loads
        for (int c = 0; c < 400; c++) begin
            fetch_en = 1'($urandom_range(0, 1));
            prog_sel = PSW'($urandom_range(0, NPROG - 1));
            address  = ADDR_W'($urandom_range(0, 20));
            if ($urandom_range(0, 19) == 0) begin
                int nw;
                start_load($urandom_range(0, DEPTH - 1));
                nw = $urandom_range(1, 4);
                for (int w = 0; w < nw; w++) begin
                    if (w == 1 && $urandom_range(0, 3) == 0)
                        start_load($urandom_range(0, DEPTH - 1));
                    send_word($urandom, w == nw - 1, $urandom_range(0, 2));
                end
            end else begin
                step();
            end
        end

        fetch_en = 1'b0;
        repeat (3) step();
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
